// File: rtl/palette_pkg.sv
// Shared fade-state encoding, default widths and the RGB triple type for palette_lut.
package palette_pkg;

  localparam int DEF_INDEX_W = 4;
  localparam int DEF_COLOR_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    FADE_OUT,
    FADE_IN
  } fade_state_e;

  typedef struct packed {
    logic [DEF_COLOR_W-1:0] red;
    logic [DEF_COLOR_W-1:0] green;
    logic [DEF_COLOR_W-1:0] blue;
  } rgb_t;

endpackage

// File: rtl/palette_fade_ctrl.sv
// Brightness fade controller: step divider, level L and fade FSM.
// Instantiated by palette_lut only when PALETTE_LUT_FADE_EN is defined.
module palette_fade_ctrl
  import palette_pkg::*;
#(
  parameter int COLOR_W  = DEF_COLOR_W,
  parameter int FADE_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fade_start,
  input  logic             fade_dir,
  output logic [COLOR_W:0] level,
  output logic             fade_busy
);

  localparam int                 DIV_W      = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(FADE_DIV - 1);
  localparam logic [DIV_W-1:0]   DIV_ONE    = DIV_W'(1);
  localparam logic [COLOR_W:0]   LEVEL_MAX  = {1'b1, {COLOR_W{1'b0}}};
  localparam logic [COLOR_W:0]   LEVEL_ONE  = (COLOR_W + 1)'(1);
  localparam logic [COLOR_W:0]   LEVEL_PRE  = LEVEL_MAX - LEVEL_ONE;

  fade_state_e       state_q;
  logic [DIV_W-1:0]  div_q;
  logic [COLOR_W:0]  level_q;
  logic              busy_q;

  // NOTE: every flop here uses <= so each branch sees pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      div_q   <= '0;
      level_q <= LEVEL_MAX;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (fade_start) begin
            state_q <= fade_dir ? FADE_OUT : FADE_IN;
            div_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        FADE_OUT: begin
          if (div_q == DIV_LAST) begin
            div_q <= '0;
            if (level_q != '0) level_q <= level_q - LEVEL_ONE;
            // A fade that starts at its target still waits for one step boundary.
            if (level_q == '0 || level_q == LEVEL_ONE) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            div_q <= div_q + DIV_ONE;
          end
        end
        FADE_IN: begin
          if (div_q == DIV_LAST) begin
            div_q <= '0;
            if (level_q != LEVEL_MAX) level_q <= level_q + LEVEL_ONE;
            if (level_q == LEVEL_MAX || level_q == LEVEL_PRE) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            div_q <= div_q + DIV_ONE;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign level     = level_q;
  assign fade_busy = busy_q;

endmodule

// File: rtl/palette_lut.sv
// Palette lookup: register-array palette, 2-stage lookup pipeline, optional
// brightness fade/scaling enabled by defining PALETTE_LUT_FADE_EN.
module palette_lut
  import palette_pkg::*;
#(
  parameter int INDEX_W  = DEF_INDEX_W,
  parameter int COLOR_W  = DEF_COLOR_W,
  parameter int FADE_DIV = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [INDEX_W-1:0]   wr_addr,
  input  logic [3*COLOR_W-1:0] wr_rgb,
  input  logic                 pix_valid,
  input  logic [INDEX_W-1:0]   pix_index,
  input  logic                 fade_start,
  input  logic                 fade_dir,
  output logic                 out_valid,
  output logic [COLOR_W-1:0]   red,
  output logic [COLOR_W-1:0]   green,
  output logic [COLOR_W-1:0]   blue,
  output logic                 fade_busy
);

  localparam int ENTRIES = 2 ** INDEX_W;
  localparam int RGB_W   = 3 * COLOR_W;

  logic [RGB_W-1:0] palette_q [ENTRIES];
  logic [RGB_W-1:0] palette_d [ENTRIES];
  logic             s1_valid_q, s1_valid_d;
  logic [RGB_W-1:0] s1_rgb_q, s1_rgb_d;
  logic             out_valid_q, out_valid_d;
  logic [RGB_W-1:0] out_rgb_q, out_rgb_d;
  logic [RGB_W-1:0] scaled_rgb;

  // NOTE: palette_d starts as a copy of palette_q so every path assigns it and no latch is inferred.
  always_comb begin
    palette_d = palette_q;
    if (wr_en) palette_d[wr_addr] = wr_rgb;
  end

  // Stage 1 reads the pre-write palette, so a same-cycle write/read returns the old entry.
  always_comb begin
    s1_valid_d  = pix_valid;
    s1_rgb_d    = palette_q[pix_index];
    out_valid_d = s1_valid_q;
    out_rgb_d   = s1_valid_q ? scaled_rgb : out_rgb_q;
  end

`ifdef PALETTE_LUT_FADE_EN
  localparam int PROD_W = 2 * COLOR_W + 1;

  logic [COLOR_W:0] level;

  palette_fade_ctrl #(
    .COLOR_W  (COLOR_W),
    .FADE_DIV (FADE_DIV)
  ) u_fade_ctrl (
    .clk        (clk),
    .rst        (rst),
    .fade_start (fade_start),
    .fade_dir   (fade_dir),
    .level      (level),
    .fade_busy  (fade_busy)
  );

  function automatic logic [COLOR_W-1:0] scale_chan(input logic [COLOR_W-1:0] c,
                                                    input logic [COLOR_W:0]   l);
    logic [PROD_W-1:0] prod;
    prod = PROD_W'(c) * PROD_W'(l);
    return COLOR_W'(prod >> COLOR_W);
  endfunction

  always_comb begin
    scaled_rgb = {scale_chan(s1_rgb_q[RGB_W-1 -: COLOR_W], level),
                  scale_chan(s1_rgb_q[2*COLOR_W-1 -: COLOR_W], level),
                  scale_chan(s1_rgb_q[COLOR_W-1:0], level)};
  end
`else
  localparam int unused_fade_div = FADE_DIV;
  logic          unused_fade_inputs;

  assign unused_fade_inputs = ^{fade_start, fade_dir};
  assign scaled_rgb         = s1_rgb_q;
  assign fade_busy          = 1'b0;
`endif

  // NOTE: the palette is a flop array rather than a RAM, so it takes a per-entry grey reset value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) palette_q[i] <= {3{COLOR_W'(i)}};
      s1_valid_q  <= 1'b0;
      s1_rgb_q    <= '0;
      out_valid_q <= 1'b0;
      out_rgb_q   <= '0;
    end else begin
      palette_q   <= palette_d;
      s1_valid_q  <= s1_valid_d;
      s1_rgb_q    <= s1_rgb_d;
      out_valid_q <= out_valid_d;
      out_rgb_q   <= out_rgb_d;
    end
  end

  assign out_valid = out_valid_q;
  assign red       = out_rgb_q[RGB_W-1 -: COLOR_W];
  assign green     = out_rgb_q[2*COLOR_W-1 -: COLOR_W];
  assign blue      = out_rgb_q[COLOR_W-1:0];

endmodule

// File: tb/tb_palette_lut.sv
// Self-checking bench for palette_lut; fade expectations follow PALETTE_LUT_FADE_EN.
module tb_palette_lut;
  import palette_pkg::*;

  localparam int INDEX_W  = DEF_INDEX_W;
  localparam int COLOR_W  = DEF_COLOR_W;
  localparam int FADE_DIV = 4;
  localparam int ENTRIES  = 1 << INDEX_W;
  localparam int FULL     = 1 << COLOR_W;
`ifdef PALETTE_LUT_FADE_EN
  localparam bit FADE_EN = 1'b1;
`else
  localparam bit FADE_EN = 1'b0;
`endif

  logic                 clk        = 1'b0;
  logic                 rst        = 1'b1;
  logic                 wr_en      = 1'b0;
  logic [INDEX_W-1:0]   wr_addr    = '0;
  logic [3*COLOR_W-1:0] wr_rgb     = '0;
  logic                 pix_valid  = 1'b0;
  logic [INDEX_W-1:0]   pix_index  = '0;
  logic                 fade_start = 1'b0;
  logic                 fade_dir   = 1'b0;
  logic                 out_valid;
  logic [COLOR_W-1:0]   red, green, blue;
  logic                 fade_busy;

  palette_lut #(
    .INDEX_W  (INDEX_W),
    .COLOR_W  (COLOR_W),
    .FADE_DIV (FADE_DIV)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_rgb     (wr_rgb),
    .pix_valid  (pix_valid),
    .pix_index  (pix_index),
    .fade_start (fade_start),
    .fade_dir   (fade_dir),
    .out_valid  (out_valid),
    .red        (red),
    .green      (green),
    .blue       (blue),
    .fade_busy  (fade_busy)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;

  // Reference model state: palette contents, fade timeline, one pending lookup.
  rgb_t mem_m [ENTRIES];
  int   edge_n = 0;
  bit   f_active;
  int   f_t0, f_l0;
  bit   f_dir;
  int   lvl_m;
  bit   busy_m;
  bit   pend_valid;
  rgb_t pend_rgb;
  bit   exp_valid;
  rgb_t exp_rgb;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int scale(input int c, input int l);
    return (c * l) / FULL;
  endfunction

  function automatic rgb_t scale_rgb(input rgb_t c, input int l);
    rgb_t s;
    s.red   = COLOR_W'(scale(int'(c.red), l));
    s.green = COLOR_W'(scale(int'(c.green), l));
    s.blue  = COLOR_W'(scale(int'(c.blue), l));
    return s;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) mem_m[i] = {3{COLOR_W'(i % FULL)}};
    f_active   = 1'b0;
    lvl_m      = FULL;
    busy_m     = 1'b0;
    pend_valid = 1'b0;
    pend_rgb   = '0;
    exp_valid  = 1'b0;
    exp_rgb    = '0;
  endtask

  // Level is derived from elapsed cycles since the accepted fade_start.
  task automatic model_edge();
    rgb_t rd;
    int   el, steps, span;
    exp_valid = pend_valid;
    if (pend_valid) exp_rgb = pend_rgb;
    rd = mem_m[pix_index];
    if (wr_en) mem_m[wr_addr] = wr_rgb;
    edge_n++;
    if (FADE_EN && fade_start && !busy_m) begin
      f_active = 1'b1;
      f_t0     = edge_n;
      f_l0     = lvl_m;
      f_dir    = fade_dir;
    end
    if (f_active) begin
      el    = edge_n - f_t0;
      steps = el / FADE_DIV;
      span  = f_dir ? f_l0 : FULL - f_l0;
      if (span == 0) span = 1;
      busy_m = (el < span * FADE_DIV);
      if (f_dir) lvl_m = (f_l0 - steps < 0) ? 0 : f_l0 - steps;
      else       lvl_m = (f_l0 + steps > FULL) ? FULL : f_l0 + steps;
    end
    pend_valid = pix_valid;
    pend_rgb   = scale_rgb(rd, lvl_m);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check("out_valid", out_valid, exp_valid);
    check("rgb", {red, green, blue}, exp_rgb);
    check("fade_busy", fade_busy, busy_m);
  endtask

  task automatic idle();
    pix_valid  = 1'b0;
    wr_en      = 1'b0;
    fade_start = 1'b0;
    fade_dir   = 1'b0;
  endtask

  task automatic read(input int idx);
    pix_valid = 1'b1;
    pix_index = INDEX_W'(idx);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nbusy;
    int nvalid;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_rgb", {red, green, blue}, 12'h000);
    check("reset_fade_busy", fade_busy, 1'b0);
    rst = 1'b0;

    // Single lookup of grey entry 5, two-cycle latency.
    read(5); cyc();
    idle();  cyc();
    check("lat2_valid", out_valid, 1'b1);
    check("lat2_rgb", {red, green, blue}, 12'h555);
    cyc();

    // Back-to-back ramp over every entry.
    nvalid = 0;
    for (int i = 0; i < ENTRIES + 2; i++) begin
      if (i < ENTRIES) read(i); else idle();
      cyc();
      if (out_valid === 1'b1) nvalid++;
    end
    check("ramp_valid_cycles", nvalid, ENTRIES);

    // Same-cycle write and read of entry 3 returns the old value.
    wr_en = 1'b1; wr_addr = 3; wr_rgb = 12'hF08; read(3); cyc();
    idle(); read(3); cyc();
    check("wr_rd_same_cycle", {red, green, blue}, 12'h333);
    idle(); cyc();
    check("wr_rd_next_cycle", {red, green, blue}, 12'hF08);

    // Fade to black from full brightness; a second start mid-fade is ignored.
    wr_en = 1'b1; wr_addr = 15; wr_rgb = 12'hFFF; cyc();
    idle(); fade_start = 1'b1; fade_dir = 1'b1; read(15); cyc();
    nbusy = (fade_busy === 1'b1) ? 1 : 0;
    for (int k = 1; k <= 70; k++) begin
      fade_start = (k == 10);
      fade_dir   = 1'b0;
      read(15);
      cyc();
      if (fade_busy === 1'b1) nbusy++;
      if (k == 34) check("fade_level8", {red, green, blue}, FADE_EN ? 12'h777 : 12'hFFF);
    end
    check("fade_out_busy_cycles", nbusy, FADE_EN ? 64 : 0);
    check("fade_out_end", {red, green, blue}, FADE_EN ? 12'h000 : 12'hFFF);

    // Fade back to full brightness.
    idle(); fade_start = 1'b1; fade_dir = 1'b0; read(15); cyc();
    fade_start = 1'b0;
    for (int k = 0; k < 70; k++) begin read(15); cyc(); end
    check("fade_in_end", {red, green, blue}, 12'hFFF);

    // Fade-in requested while already at full level: brief busy, no level change.
    idle(); fade_start = 1'b1; fade_dir = 1'b0; read(15); cyc();
    nbusy = (fade_busy === 1'b1) ? 1 : 0;
    fade_start = 1'b0;
    for (int k = 0; k < 9; k++) begin
      read(15); cyc();
      if (fade_busy === 1'b1) nbusy++;
    end
    check("at_target_busy_cycles", nbusy, FADE_EN ? FADE_DIV : 0);
    check("at_target_level", {red, green, blue}, 12'hFFF);

    // Randomized writes, lookups and occasional fades.
    for (int k = 0; k < 300; k++) begin
      pix_valid  = ($urandom_range(3) != 0);
      pix_index  = INDEX_W'($urandom());
      wr_en      = ($urandom_range(2) == 0);
      wr_addr    = INDEX_W'($urandom());
      wr_rgb     = (3 * COLOR_W)'($urandom());
      fade_start = ($urandom_range(39) == 0);
      fade_dir   = 1'($urandom_range(1));
      cyc();
    end
    idle();
    for (int k = 0; k < 200 && busy_m; k++) cyc();
    if (lvl_m != FULL) begin
      fade_start = 1'b1; fade_dir = 1'b0; cyc();
      idle();
      for (int k = 0; k < 200 && busy_m; k++) cyc();
    end
    cyc();

    // Reset in the middle of a fade (level 9) with lookups in flight.
    fade_start = 1'b1; fade_dir = 1'b1; read(15); cyc();
    fade_start = 1'b0;
    for (int k = 0; k < 28; k++) begin read(k % ENTRIES); cyc(); end
    #2;
    rst = 1'b1;
    idle();
    model_reset();
    #1;
    check("midreset_out_valid", out_valid, 1'b0);
    check("midreset_rgb", {red, green, blue}, 12'h000);
    check("midreset_fade_busy", fade_busy, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc();
    check("postreset_out_valid", out_valid, 1'b0);
    for (int i = 0; i < ENTRIES + 2; i++) begin
      if (i < ENTRIES) read(i); else idle();
      cyc();
    end
    check("postreset_grey_level", {red, green, blue}, 12'hFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
